decode_control_fsm: RTL and testbench
=====================================

// Module: decode_control_fsm
// PURPOSE
//  Registered, stall-aware successor of the ID-stage instruction decoder.
//  - Decodes the MIPS instruction in IF/ID into the control bundle.
//  - Registers the bundle into ID/EX and inserts bubbles on load-use hazards.
//  - Sequences multi-cycle MULT/MULTU/DIV/DIVU with parameterised latency,
//    holding the front end while the multiply/divide unit is busy.
// PARAMETERS
//  NB            32  instruction width
//  NB_REGS        5  register-address width
//  NB_OPCODE      6  opcode/funct width
//  NB_SIZE_TYPE   3  word-size code width
//  MUL_LATENCY    4  stall cycles for MULT/MULTU (must be >=1)
//  DIV_LATENCY   32  stall cycles for DIV/DIVU (must be >=1)
// PORTS
//  i_clk            in   1             clock, rising edge
//  i_reset          in   1             reset: asynchronous, active-high
//  i_instruction    in   NB            IF/ID instruction
//  i_valid          in   1             IF/ID holds a real instruction
//  i_flush          in   1             branch/jump flush: kill the next bundle
//  o_alu_src..o_jr_jalr  out  1 each   registered control (same semantics as the decoder)
//  o_reg_dir_to_write  out  NB_REGS    registered destination register
//  o_signed         out  1             registered load sign flag
//  o_ExtensionMode  out  2             registered immediate extension mode
//  o_word_size      out  NB_SIZE_TYPE  registered memory access size
//  o_md_start       out  1             one-cycle pulse: start the mul/div unit
//  o_md_op          out  2             00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  o_stall          out  1             comb.: hold PC and IF/ID this cycle
//  o_busy           out  1             registered: FSM in BUSY
// BEHAVIOUR
//  Reset (async): all control bits 0, o_reg_dir_to_write 0,
//   o_ExtensionMode=`SIGNED_EXTENSION_MODE, o_word_size=`COMPLETE_WORD,
//   o_md_op 0, FSM=IDLE, counter 0. o_stall=0 while in reset.
//  Decode: field map opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
//   Opcode/funct table is unchanged; unknown opcodes decode to the bubble bundle.
//  Latency: one cycle. Bundle decoded in cycle N appears on outputs in N+1.
//  Bubble: the reset-value bundle.
//  Next-bundle priority, per edge: flush > load-use > BUSY > decode.
//   - i_flush=1: bubble; BUSY aborts to IDLE with counter cleared. o_stall=0.
//   - load-use: o_mem_read=1 and o_reg_dir_to_write!=0, and it equals rs, or
//     rt when the instruction reads rt (R-type, branches, stores).
//     -> o_stall=1 and a bubble is issued. The same instruction re-decodes next cycle.
//   - BUSY: bubble; o_stall=1.
//   - !i_valid: bubble; o_stall=0.
//  FSM IDLE: accept a MULT/MULTU/DIV/DIVU (funct 18/19/1A/1B) with no hazard
//   -> register a bundle with o_reg_write=0 and o_md_start=1 (pulse), set o_md_op,
//   load counter=LAT, go to BUSY.
//  FSM BUSY: o_stall=1; decrement the counter each cycle; at counter==1 go to IDLE.
//   If accepted in cycle N: o_stall is high N+1..N+LAT; the next accept is at N+LAT+1.
//  Counter width is $clog2(max(MUL_LATENCY,DIV_LATENCY)+1); the counter never wraps.
//  o_md_start is never high two cycles in a row.
//  Reset mid-BUSY: IDLE immediately, with no o_md_start.
// STRUCTURE
//  Shared headers: opcode/funct codes in instruction_constants.vh; add MULT/
//   MULTU/DIV/DIVU funct codes and MD_OP codes there. Extension mode, ALU-src
//   and word-size codes come from decode_constants.vh / memory_constants.vh.
//   Add FSM state encodings (IDLE=0, BUSY=1) to decode_constants.vh.
//  One sub-module: control_decode_comb, a pure combinational opcode/funct to
//   bundle table. The top level holds the hazard comparator, FSM, counter and
//   output registers.
// TESTING
//  1. Reset with ADDI $t1,$0,5 on input -> all outputs at reset values; one cycle
//     after release: reg_write=1, alu_src=imm, dir=9.
//  2. LW $t0,0($s0) then ADD $t2,$t0,$t1 -> o_stall=1 for one cycle, one bubble,
//     then the ADD bundle with dir=10.
//  3. LW $0 then ADD using $0 -> no stall; LW $t0 then SW $t0 -> stall (rt used).
//  4. MULT with MUL_LATENCY=4 -> o_md_start pulse with o_md_op=00, o_stall high 4
//     cycles, next instruction accepted on cycle 5; DIV -> 32 cycles with op=10.
//  5. i_flush on the 2nd BUSY cycle of DIV -> bubble, o_busy=0, o_stall=0 next cycle.
//  6. Async i_reset pulse between edges during BUSY -> outputs at reset values and
//     FSM IDLE before the next edge; unknown opcode 6'h3F -> bubble bundle.

Source files
------------

// File: rtl/decode_control_fsm_pkg.sv
// Shared constants for the registered ID-stage decoder: opcode/funct codes,
// control-field encodings, FSM states and the control bundle layout.
package decode_control_fsm_pkg;

    localparam int REG_W  = 5;
    localparam int SIZE_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_LWU   = 6'h27;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    localparam logic [1:0] SIGNED_EXTENSION_MODE   = 2'b00;
    localparam logic [1:0] UNSIGNED_EXTENSION_MODE = 2'b01;
    localparam logic [1:0] LUI_EXTENSION_MODE      = 2'b10;

    localparam logic [SIZE_W-1:0] BYTE_WORD     = 3'b001;
    localparam logic [SIZE_W-1:0] HALF_WORD     = 3'b010;
    localparam logic [SIZE_W-1:0] COMPLETE_WORD = 3'b100;

    localparam logic ALU_SRC_REG = 1'b0;
    localparam logic ALU_SRC_IMM = 1'b1;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;

    typedef struct packed {
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              branch_ne;
        logic              jump;
        logic              jr_jalr;
        logic [REG_W-1:0]  reg_dir;
        logic              sgn;
        logic [1:0]        ext_mode;
        logic [SIZE_W-1:0] word_size;
        logic              md_start;
        logic [1:0]        md_op;
    } ctrl_bundle_t;

    localparam int BUNDLE_W = $bits(ctrl_bundle_t);

    function automatic ctrl_bundle_t bubble_bundle();
        ctrl_bundle_t b;
        b           = '0;
        b.ext_mode  = SIGNED_EXTENSION_MODE;
        b.word_size = COMPLETE_WORD;
        return b;
    endfunction

    function automatic logic [SIZE_W-1:0] mem_size(input logic [5:0] opcode);
        case (opcode)
            OP_LB, OP_LBU, OP_SB: return BYTE_WORD;
            OP_LH, OP_LHU, OP_SH: return HALF_WORD;
            default:              return COMPLETE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/control_decode_comb.sv
// Pure combinational opcode/funct to control-bundle table for the ID stage.
// Unknown encodings produce the bubble bundle.
module control_decode_comb
    import decode_control_fsm_pkg::*;
#(
    parameter int NB        = 32,
    parameter int NB_REGS   = 5,
    parameter int NB_OPCODE = 6
) (
    input  logic [NB-1:0]       i_instruction,
    output logic [BUNDLE_W-1:0] o_bundle,
    output logic [NB_REGS-1:0]  o_rs,
    output logic [NB_REGS-1:0]  o_rt,
    output logic                o_reads_rt
);

    logic [NB_OPCODE-1:0] opcode;
    logic [NB_OPCODE-1:0] funct;
    logic [NB_REGS-1:0]   rd;
    logic                 unused_shamt;
    ctrl_bundle_t         b;
    logic                 reads_rt;

    assign opcode       = i_instruction[NB-1 -: NB_OPCODE];
    assign o_rs         = i_instruction[NB-NB_OPCODE-1 -: NB_REGS];
    assign o_rt         = i_instruction[NB-NB_OPCODE-NB_REGS-1 -: NB_REGS];
    assign rd           = i_instruction[NB-NB_OPCODE-2*NB_REGS-1 -: NB_REGS];
    assign funct        = i_instruction[NB_OPCODE-1:0];
    assign unused_shamt = ^i_instruction[NB-NB_OPCODE-3*NB_REGS-1:NB_OPCODE];

    always_comb begin
        b        = bubble_bundle();
        reads_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reads_rt = 1'b1;
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        b.reg_write = 1'b1;
                        b.reg_dir   = rd;
                    end
                    FN_JR: b.jr_jalr = 1'b1;
                    FN_JALR: begin
                        b.jr_jalr   = 1'b1;
                        b.reg_write = 1'b1;
                        b.reg_dir   = rd;
                    end
                    // funct[1:0] of 18..1B lines up with the MD_OP codes
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        b.md_start = 1'b1;
                        b.md_op    = funct[1:0];
                    end
                    default: ;
                endcase
            end
            OP_J: b.jump = 1'b1;
            OP_JAL: begin
                b.jump      = 1'b1;
                b.reg_write = 1'b1;
                b.reg_dir   = '1;
            end
            OP_BEQ, OP_BNE: begin
                reads_rt    = 1'b1;
                b.branch    = 1'b1;
                b.branch_ne = (opcode == OP_BNE);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                b.alu_src   = ALU_SRC_IMM;
                b.reg_write = 1'b1;
                b.reg_dir   = o_rt;
                if (opcode == OP_LUI)
                    b.ext_mode = LUI_EXTENSION_MODE;
                else if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
                    b.ext_mode = UNSIGNED_EXTENSION_MODE;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                b.alu_src    = ALU_SRC_IMM;
                b.reg_write  = 1'b1;
                b.mem_read   = 1'b1;
                b.mem_to_reg = 1'b1;
                b.reg_dir    = o_rt;
                b.sgn        = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW);
                b.word_size  = mem_size(opcode);
            end
            OP_SB, OP_SH, OP_SW: begin
                reads_rt    = 1'b1;
                b.alu_src   = ALU_SRC_IMM;
                b.mem_write = 1'b1;
                b.word_size = mem_size(opcode);
            end
            default: ;
        endcase
    end

    assign o_bundle   = b;
    assign o_reads_rt = reads_rt;

endmodule

// File: rtl/decode_control_fsm.sv
// Registered, stall-aware ID-stage decoder: load-use bubbles, flush handling
// and a multi-cycle MULT/DIV sequencer that holds the front end while busy.
module decode_control_fsm
    import decode_control_fsm_pkg::*;
#(
    parameter int NB           = 32,
    parameter int NB_REGS      = 5,
    parameter int NB_OPCODE    = 6,
    parameter int NB_SIZE_TYPE = 3,
    parameter int MUL_LATENCY  = 4,
    parameter int DIV_LATENCY  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NB-1:0]           i_instruction,
    input  logic                    i_valid,
    input  logic                    i_flush,
    output logic                    o_alu_src,
    output logic                    o_reg_write,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic                    o_mem_to_reg,
    output logic                    o_branch,
    output logic                    o_branch_ne,
    output logic                    o_jump,
    output logic                    o_jr_jalr,
    output logic [NB_REGS-1:0]      o_reg_dir_to_write,
    output logic                    o_signed,
    output logic [1:0]              o_ExtensionMode,
    output logic [NB_SIZE_TYPE-1:0] o_word_size,
    output logic                    o_md_start,
    output logic [1:0]              o_md_op,
    output logic                    o_stall,
    output logic                    o_busy
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY);

    logic [BUNDLE_W-1:0] dec_bits;
    ctrl_bundle_t        dec;
    ctrl_bundle_t        bundle_d, bundle_q;
    logic [0:0]          state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [NB_REGS-1:0]  rs, rt;
    logic                reads_rt;
    logic                hazard;
    logic                stall;

    control_decode_comb #(
        .NB        (NB),
        .NB_REGS   (NB_REGS),
        .NB_OPCODE (NB_OPCODE)
    ) u_decode (
        .i_instruction (i_instruction),
        .o_bundle      (dec_bits),
        .o_rs          (rs),
        .o_rt          (rt),
        .o_reads_rt    (reads_rt)
    );

    assign dec = ctrl_bundle_t'(dec_bits);

    // Load in EX writing a register this instruction reads; $0 never hazards.
    assign hazard = i_valid && bundle_q.mem_read && (bundle_q.reg_dir != '0) &&
                    ((bundle_q.reg_dir == rs) || (reads_rt && (bundle_q.reg_dir == rt)));

    always_comb begin
        bundle_d = bubble_bundle();
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        if (i_flush) begin
            state_d = STATE_IDLE;
            cnt_d   = '0;
        end else if (hazard) begin
            stall = 1'b1;
        end else if (state_q == STATE_BUSY) begin
            stall = 1'b1;
            if (cnt_q <= 1) begin
                state_d = STATE_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (i_valid) begin
            bundle_d = dec;
            if (dec.md_start) begin
                state_d = STATE_BUSY;
                cnt_d   = dec.md_op[1] ? DIV_CNT : MUL_CNT;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bundle_q <= bubble_bundle();
            state_q  <= STATE_IDLE;
            cnt_q    <= '0;
        end else begin
            bundle_q <= bundle_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_stall            = stall && !i_reset;
    assign o_busy             = (state_q == STATE_BUSY);
    assign o_alu_src          = bundle_q.alu_src;
    assign o_reg_write        = bundle_q.reg_write;
    assign o_mem_read         = bundle_q.mem_read;
    assign o_mem_write        = bundle_q.mem_write;
    assign o_mem_to_reg       = bundle_q.mem_to_reg;
    assign o_branch           = bundle_q.branch;
    assign o_branch_ne        = bundle_q.branch_ne;
    assign o_jump             = bundle_q.jump;
    assign o_jr_jalr          = bundle_q.jr_jalr;
    assign o_reg_dir_to_write = bundle_q.reg_dir;
    assign o_signed           = bundle_q.sgn;
    assign o_ExtensionMode    = bundle_q.ext_mode;
    assign o_word_size        = bundle_q.word_size;
    assign o_md_start         = bundle_q.md_start;
    assign o_md_op            = bundle_q.md_op;

endmodule

// File: tb/tb_decode_control_fsm.sv
// Directed scenarios plus randomized instruction streams against a
// cycle-level reference model of the registered decoder.
module tb_decode_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        valid, flush;
    logic        o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
    logic        o_branch, o_branch_ne, o_jump, o_jr_jalr, o_signed;
    logic [4:0]  o_reg_dir_to_write;
    logic [1:0]  o_ExtensionMode, o_md_op;
    logic [2:0]  o_word_size;
    logic        o_md_start, o_stall, o_busy;

    always #5 clk = ~clk;

    decode_control_fsm dut (
        .i_clk(clk), .i_reset(rst), .i_instruction(instr), .i_valid(valid), .i_flush(flush),
        .o_alu_src(o_alu_src), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg), .o_branch(o_branch),
        .o_branch_ne(o_branch_ne), .o_jump(o_jump), .o_jr_jalr(o_jr_jalr),
        .o_reg_dir_to_write(o_reg_dir_to_write), .o_signed(o_signed),
        .o_ExtensionMode(o_ExtensionMode), .o_word_size(o_word_size),
        .o_md_start(o_md_start), .o_md_op(o_md_op), .o_stall(o_stall), .o_busy(o_busy)
    );

    typedef struct packed {
        logic       alu_src, reg_write, mem_read, mem_write, mem_to_reg;
        logic       branch, branch_ne, jump, jr_jalr;
        logic [4:0] dir;
        logic       sgn;
        logic [1:0] ext;
        logic [2:0] ws;
        logic       md_start;
        logic [1:0] md_op;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t m_q;
    int   m_busy_left;
    logic s_stall;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t bubble();
        exp_t e;
        e    = '0;
        e.ws = 3'b100;
        return e;
    endfunction

    function automatic logic [2:0] size_of(input logic [5:0] op);
        if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 3'b001;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 3'b010;
        return 3'b100;
    endfunction

    // Reference decode table written directly from the MIPS instruction set.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t       e;
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        e  = bubble();
        case (op)
            6'h00: begin
                if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B}) begin
                    e.reg_write = 1; e.dir = ins[15:11];
                end else if (fn == 6'h08) begin
                    e.jr_jalr = 1;
                end else if (fn == 6'h09) begin
                    e.jr_jalr = 1; e.reg_write = 1; e.dir = ins[15:11];
                end else if (fn == 6'h18 || fn == 6'h19 || fn == 6'h1A || fn == 6'h1B) begin
                    e.md_start = 1;
                    e.md_op    = (fn == 6'h18) ? 2'd0 : (fn == 6'h19) ? 2'd1 : (fn == 6'h1A) ? 2'd2 : 2'd3;
                end
            end
            6'h02: e.jump = 1;
            6'h03: begin e.jump = 1; e.reg_write = 1; e.dir = 5'd31; end
            6'h04: e.branch = 1;
            6'h05: begin e.branch = 1; e.branch_ne = 1; end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin e.alu_src = 1; e.reg_write = 1; e.dir = ins[20:16]; end
            6'h0C, 6'h0D, 6'h0E: begin e.alu_src = 1; e.reg_write = 1; e.dir = ins[20:16]; e.ext = 2'b01; end
            6'h0F: begin e.alu_src = 1; e.reg_write = 1; e.dir = ins[20:16]; e.ext = 2'b10; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27: begin
                e.alu_src = 1; e.reg_write = 1; e.mem_read = 1; e.mem_to_reg = 1;
                e.dir = ins[20:16]; e.sgn = (op < 6'h24); e.ws = size_of(op);
            end
            6'h28, 6'h29, 6'h2B: begin e.alu_src = 1; e.mem_write = 1; e.ws = size_of(op); end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit ref_reads_rt(input logic [31:0] ins);
        return ins[31:26] inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic bit ref_hazard();
        return valid && m_q.mem_read && (m_q.dir != 0) &&
               ((m_q.dir == instr[25:21]) || (ref_reads_rt(instr) && (m_q.dir == instr[20:16])));
    endfunction

    function automatic exp_t got_bundle();
        return {o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch,
                o_branch_ne, o_jump, o_jr_jalr, o_reg_dir_to_write, o_signed,
                o_ExtensionMode, o_word_size, o_md_start, o_md_op};
    endfunction

    task automatic cycle();
        exp_t nxt;
        int   nbusy;
        bit   hz, exp_stall;
        @(negedge clk);
        hz        = ref_hazard();
        exp_stall = !rst && !flush && (hz || m_busy_left > 0);
        check_val("stall", 32'(o_stall), 32'(exp_stall));
        check_val("busy", 32'(o_busy), 32'(m_busy_left > 0));
        check_val("bundle", 32'(got_bundle()), 32'(m_q));
        s_stall = o_stall;
        nxt     = bubble();
        nbusy   = m_busy_left;
        if (rst || flush) begin
            nbusy = 0;
        end else if (hz) begin
            nbusy = m_busy_left;
        end else if (m_busy_left > 0) begin
            nbusy = m_busy_left - 1;
        end else if (valid) begin
            nxt = ref_decode(instr);
            if (nxt.md_start) nbusy = nxt.md_op[1] ? 32 : 4;
        end
        @(posedge clk);
        m_q         = nxt;
        m_busy_left = nbusy;
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'($urandom), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'd10;
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [15:0] imm;
        imm = 16'($urandom);
        case ($urandom_range(0, 16))
            0:  return enc_r(($urandom_range(0, 1) == 0) ? 6'h20 : 6'h2A, rreg(), rreg(), rreg());
            1:  return enc_r(6'h08, rreg(), rreg(), rreg());
            2:  return enc_r(6'h09, rreg(), rreg(), rreg());
            3:  return enc_r(($urandom_range(0, 3) == 0) ? 6'(6'h18 + $urandom_range(0, 3)) : 6'h22,
                             rreg(), rreg(), rreg());
            4:  return enc_i(6'h08, rreg(), rreg(), imm);
            5:  return enc_i(6'h0D, rreg(), rreg(), imm);
            6:  return enc_i(6'h0F, rreg(), rreg(), imm);
            7:  return enc_i(6'h23, rreg(), rreg(), imm);
            8:  return enc_i(6'h20, rreg(), rreg(), imm);
            9:  return enc_i(6'h25, rreg(), rreg(), imm);
            10: return enc_i(6'h2B, rreg(), rreg(), imm);
            11: return enc_i(6'h28, rreg(), rreg(), imm);
            12: return enc_i(6'h04, rreg(), rreg(), imm);
            13: return enc_i(6'h05, rreg(), rreg(), imm);
            14: return {6'h02, 26'($urandom)};
            15: return {6'h03, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] ADDI_T1 = {6'h08, 5'd0, 5'd9, 16'd5};
    localparam logic [31:0] LW_T0   = {6'h23, 5'd16, 5'd8, 16'd0};
    localparam logic [31:0] LW_ZERO = {6'h23, 5'd16, 5'd0, 16'd0};
    localparam logic [31:0] SW_T0   = {6'h2B, 5'd16, 5'd8, 16'd0};
    localparam logic [31:0] ADD_T2  = {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] ADD_Z   = {6'h00, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] MULT_I  = {6'h00, 5'd9, 5'd10, 5'd0, 5'd0, 6'h18};
    localparam logic [31:0] DIV_I   = {6'h00, 5'd9, 5'd10, 5'd0, 5'd0, 6'h1A};

    initial begin
        int n;
        rst = 1'b1; instr = ADDI_T1; valid = 1'b1; flush = 1'b0;
        m_q = bubble(); m_busy_left = 0; s_stall = 1'b0;
        @(posedge clk); #1;
        cycle(); cycle();
        check_val("rst_stall", 32'(o_stall), 32'd0);
        check_val("rst_ws", 32'(o_word_size), 32'd4);

        rst = 1'b0;
        cycle();
        check_val("addi_rw", 32'(o_reg_write), 32'd1);
        check_val("addi_src", 32'(o_alu_src), 32'd1);
        check_val("addi_dir", 32'(o_reg_dir_to_write), 32'd9);

        instr = LW_T0; cycle();
        instr = ADD_T2; cycle();
        check_val("lu_stall", 32'(s_stall), 32'd1);
        check_val("lu_bubble", 32'(got_bundle()), 32'(bubble()));
        cycle();
        check_val("lu_stall2", 32'(s_stall), 32'd0);
        check_val("lu_add_dir", 32'(o_reg_dir_to_write), 32'd10);

        instr = LW_ZERO; cycle();
        instr = ADD_Z; cycle();
        check_val("lu_zero", 32'(s_stall), 32'd0);
        instr = LW_T0; cycle();
        instr = SW_T0; cycle();
        check_val("lu_rt", 32'(s_stall), 32'd1);
        cycle();

        instr = MULT_I; cycle();
        check_val("mul_start", 32'(o_md_start), 32'd1);
        check_val("mul_op", 32'(o_md_op), 32'd0);
        instr = ADD_T2; n = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (!s_stall) break;
            n++;
        end
        check_val("mul_stalls", 32'(n), 32'd4);

        instr = DIV_I; cycle();
        check_val("div_op", 32'(o_md_op), 32'd2);
        instr = ADD_T2; n = 0;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (!s_stall) break;
            n++;
        end
        check_val("div_stalls", 32'(n), 32'd32);

        instr = DIV_I; cycle();
        instr = ADD_T2; cycle();
        flush = 1'b1; cycle();
        flush = 1'b0;
        check_val("flush_busy", 32'(o_busy), 32'd0);
        cycle();
        check_val("flush_stall", 32'(s_stall), 32'd0);

        instr = DIV_I; cycle();
        instr = ADD_T2; cycle(); cycle();
        rst = 1'b1; #2;
        check_val("arst_busy", 32'(o_busy), 32'd0);
        check_val("arst_stall", 32'(o_stall), 32'd0);
        check_val("arst_bundle", 32'(got_bundle()), 32'(bubble()));
        m_q = bubble(); m_busy_left = 0;
        rst = 1'b0;
        cycle();
        check_val("arst_accept", 32'(s_stall), 32'd0);
        instr = {6'h3F, 26'h2A5A5A5};
        cycle();
        check_val("unknown_op", 32'(got_bundle()), 32'(bubble()));

        for (int k = 0; k < 1500; k++) begin
            if (!s_stall) instr = rnd_instr();
            valid = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
